// File: rtl/signed_acc_pkg.sv
// Shared helpers for the signed product accumulator: sign restoration,
// wrap/saturating add and the accumulator width legality check.
package signed_acc_pkg;

    localparam int unsigned MAX_W = 64;

    function automatic bit acc_bw_ok(input int unsigned bw, input int unsigned acc_bw);
        return (acc_bw >= bw + 2) && (acc_bw <= MAX_W - 2);
    endfunction

    // Negation happens in the wide domain, so -(2^BW-1) never wraps once cut to BW+1 bits.
    function automatic logic [MAX_W-1:0] sign_restore(input logic neg, input logic [MAX_W-1:0] mag);
        return neg ? -mag : mag;
    endfunction

    // Operands are sign-extended w-bit values; the caller keeps the low w bits.
    function automatic logic [MAX_W-1:0] sat_add(
        input  logic [MAX_W-1:0] a,
        input  logic [MAX_W-1:0] b,
        input  int unsigned      w,
        input  logic             sat,
        output logic             ovf
    );
        logic signed [MAX_W-1:0] s;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        s   = $signed(a) + $signed(b);
        hi  = $signed((MAX_W'(1) << (w - 1)) - MAX_W'(1));
        lo  = ~hi;
        ovf = (s > hi) || (s < lo);
        if (ovf && sat)
            return b[MAX_W-1] ? lo : hi;
        return s;
    endfunction

endpackage

// File: rtl/sign_restore_lane.sv
// One accumulator lane: restores the signed product, sign-extends it and
// forms the next window sum with its sticky overflow flag.
module sign_restore_lane
    import signed_acc_pkg::*;
#(
    parameter int unsigned BW     = 8,
    parameter int unsigned ACC_BW = 20,
    parameter bit          SAT    = 1'b0
) (
    input  logic              a_sign,
    input  logic              b_sign,
    input  logic [BW-1:0]     mag,
    input  logic              first,
    input  logic [ACC_BW-1:0] acc,
    input  logic              ovf_acc,
    output logic [ACC_BW-1:0] sum,
    output logic              ovf
);

    logic [BW:0]       p_raw;
    logic [ACC_BW-1:0] p_ext;
    logic              add_ovf;

    assign p_raw = (BW+1)'(sign_restore(a_sign ^ b_sign, MAX_W'(mag)));
    assign p_ext = {{(ACC_BW-BW-1){p_raw[BW]}}, p_raw};

    always_comb begin
        add_ovf = 1'b0;
        sum = ACC_BW'(sat_add({{(MAX_W-ACC_BW){acc[ACC_BW-1]}}, acc},
                              {{(MAX_W-ACC_BW){p_ext[ACC_BW-1]}}, p_ext},
                              ACC_BW, SAT, add_ovf));
        ovf = ovf_acc | add_ovf;
        if (first) begin
            sum = p_ext;
            ovf = 1'b0;
        end
    end

endmodule

// File: rtl/signed_product_acc.sv
// Multi-lane windowed accumulator of sign-magnitude products with a
// valid/ready output register shared by all lanes.
module signed_product_acc
    import signed_acc_pkg::*;
#(
    parameter int unsigned BW     = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ACC_BW = 20,
    parameter bit          SAT    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES-1:0]        a_sign,
    input  logic [LANES-1:0]        b_sign,
    input  logic [LANES*BW-1:0]     mag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ACC_BW-1:0] out_acc,
    output logic [LANES-1:0]        out_ovf
);

    if (!acc_bw_ok(BW, ACC_BW)) begin : g_bad_acc_bw
        $error("signed_product_acc: ACC_BW must be at least BW+2");
    end

    logic                    first;
    logic                    accept;
    logic [LANES*ACC_BW-1:0] acc;
    logic [LANES*ACC_BW-1:0] sum;
    logic [LANES-1:0]        ovf_acc;
    logic [LANES-1:0]        ovf;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sign_restore_lane #(
            .BW     (BW),
            .ACC_BW (ACC_BW),
            .SAT    (SAT)
        ) u_lane (
            .a_sign  (a_sign[i]),
            .b_sign  (b_sign[i]),
            .mag     (mag[i*BW +: BW]),
            .first   (first),
            .acc     (acc[i*ACC_BW +: ACC_BW]),
            .ovf_acc (ovf_acc[i]),
            .sum     (sum[i*ACC_BW +: ACC_BW]),
            .ovf     (ovf[i])
        );
    end

    // A last beat accepted during a handoff overrides the valid clear below.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first     <= 1'b1;
            acc       <= '0;
            ovf_acc   <= '0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                if (in_last) begin
                    out_acc   <= sum;
                    out_ovf   <= ovf;
                    out_valid <= 1'b1;
                    first     <= 1'b1;
                end else begin
                    acc     <= sum;
                    ovf_acc <= ovf;
                    first   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_signed_product_acc.sv
// Scoreboard bench for signed_product_acc: one stimulus stream drives three
// configurations (20-bit wrap, 10-bit wrap, 10-bit saturate) side by side.
module tb_signed_product_acc;

    localparam int unsigned BW    = 8;
    localparam int unsigned LANES = 4;
    localparam int unsigned W0    = 20;
    localparam int unsigned W1    = 10;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_last;
    logic                   out_ready;
    logic [LANES-1:0]       a_sign;
    logic [LANES-1:0]       b_sign;
    logic [LANES*BW-1:0]    mag;
    logic                   in_ready0, in_ready1, in_ready2;
    logic                   out_valid0, out_valid1, out_valid2;
    logic [LANES*W0-1:0]    out_acc0;
    logic [LANES*W1-1:0]    out_acc1, out_acc2;
    logic [LANES-1:0]       out_ovf0, out_ovf1, out_ovf2;

    signed_product_acc #(.BW(BW), .LANES(LANES), .ACC_BW(W0), .SAT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_last(in_last), .a_sign(a_sign), .b_sign(b_sign), .mag(mag),
        .out_valid(out_valid0), .out_ready(out_ready), .out_acc(out_acc0), .out_ovf(out_ovf0)
    );
    signed_product_acc #(.BW(BW), .LANES(LANES), .ACC_BW(W1), .SAT(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_last(in_last), .a_sign(a_sign), .b_sign(b_sign), .mag(mag),
        .out_valid(out_valid1), .out_ready(out_ready), .out_acc(out_acc1), .out_ovf(out_ovf1)
    );
    signed_product_acc #(.BW(BW), .LANES(LANES), .ACC_BW(W1), .SAT(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_last(in_last), .a_sign(a_sign), .b_sign(b_sign), .mag(mag),
        .out_valid(out_valid2), .out_ready(out_ready), .out_acc(out_acc2), .out_ovf(out_ovf2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*W0-1:0] acc0;
        logic [LANES-1:0]    ovf0;
        logic [LANES*W1-1:0] acc1;
        logic [LANES-1:0]    ovf1;
        logic [LANES*W1-1:0] acc2;
        logic [LANES-1:0]    ovf2;
    } exp_t;

    exp_t q[$];
    int   win[LANES][$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Window sum by plain integer arithmetic on the list of signed products.
    function automatic void win_result(input int unsigned lane, input int unsigned w,
                                       input bit sat, output longint r, output bit o);
        longint hi, lo, s, p;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        r  = 0;
        o  = 1'b0;
        for (int j = 0; j < win[lane].size(); j++) begin
            p = longint'(win[lane][j]);
            if (j == 0) begin
                r = p;
            end else begin
                s = r + p;
                if (s > hi || s < lo) begin
                    o = 1'b1;
                    if (sat) r = (p < 0) ? lo : hi;
                    else     r = (s > hi) ? s - (hi - lo + 1) : s + (hi - lo + 1);
                end else begin
                    r = s;
                end
            end
        end
    endfunction

    task automatic model_accept(input bit last, input logic [LANES-1:0] sa,
                                input logic [LANES-1:0] sb, input logic [LANES*BW-1:0] m);
        exp_t   e;
        longint r;
        bit     o;
        int     v;
        for (int unsigned l = 0; l < LANES; l++) begin
            v = int'(m[l*BW +: BW]);
            win[l].push_back((sa[l] ^ sb[l]) ? -v : v);
        end
        if (last) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                win_result(l, W0, 1'b0, r, o);
                e.acc0[l*W0 +: W0] = W0'(r);
                e.ovf0[l]          = o;
                win_result(l, W1, 1'b0, r, o);
                e.acc1[l*W1 +: W1] = W1'(r);
                e.ovf1[l]          = o;
                win_result(l, W1, 1'b1, r, o);
                e.acc2[l*W1 +: W1] = W1'(r);
                e.ovf2[l]          = o;
            end
            for (int unsigned l = 0; l < LANES; l++) win[l].delete();
            q.push_back(e);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic drive(input bit v, input bit last, input logic [LANES-1:0] sa,
                         input logic [LANES-1:0] sb, input logic [LANES*BW-1:0] m,
                         input bit ordy, output bit took);
        bit rdy;
        in_valid  = v;
        in_last   = last;
        a_sign    = sa;
        b_sign    = sb;
        mag       = m;
        out_ready = ordy;
        @(negedge clk);
        rdy = in_ready0 && rst_n;
        @(posedge clk);
        #1;
        took = v && rdy;
        if (took) model_accept(last, sa, sb, m);
    endtask

    task automatic send(input bit last, input logic [LANES-1:0] sa,
                        input logic [LANES-1:0] sb, input logic [LANES*BW-1:0] m);
        bit took;
        took = 1'b0;
        for (int k = 0; k < 64 && !took; k++) drive(1'b1, last, sa, sb, m, 1'b1, took);
        if (!took) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got no accept, want accept within 64 cycles");
        end
    endtask

    // Monitor: every held result must match the scoreboard head; pop on handoff.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid0 === 1'b1) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got out_valid=1 with acc %0h, want no result", out_acc0);
                end else begin
                    e = q[0];
                    check("mon_acc0",   80'(out_acc0),   80'(e.acc0));
                    check("mon_ovf0",   80'(out_ovf0),   80'(e.ovf0));
                    check("mon_acc1",   80'(out_acc1),   80'(e.acc1));
                    check("mon_ovf1",   80'(out_ovf1),   80'(e.ovf1));
                    check("mon_acc2",   80'(out_acc2),   80'(e.acc2));
                    check("mon_ovf2",   80'(out_ovf2),   80'(e.ovf2));
                    check("mon_valid1", 80'(out_valid1), 80'(1));
                    check("mon_valid2", 80'(out_valid2), 80'(1));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit                  took;
        bit                  v, last, ordy;
        int unsigned         sel;
        logic [LANES*BW-1:0] mv;

        // Reset held with a last beat offered: nothing may be captured.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        a_sign    = '1;
        b_sign    = '0;
        mag       = '1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid0", 80'(out_valid0), 80'(0));
        check("rst_valid1", 80'(out_valid1), 80'(0));
        check("rst_valid2", 80'(out_valid2), 80'(0));
        check("rst_acc0",   80'(out_acc0),   80'(0));
        check("rst_acc1",   80'(out_acc1),   80'(0));
        check("rst_acc2",   80'(out_acc2),   80'(0));
        check("rst_ovf0",   80'(out_ovf0),   80'(0));
        check("rst_ovf1",   80'(out_ovf1),   80'(0));
        check("rst_ovf2",   80'(out_ovf2),   80'(0));
        rst_n = 1'b1;

        // Lane 0: +5, -255, +7; lane 1: negative zero on every beat.
        send(1'b0, {2'($urandom), 1'b1, 1'b0}, {2'($urandom), 1'b0, 1'b0},
             {8'($urandom), 8'($urandom), 8'd0, 8'd5});
        send(1'b0, {2'($urandom), 1'b1, 1'b1}, {2'($urandom), 1'b0, 1'b0},
             {8'($urandom), 8'($urandom), 8'd0, 8'd255});
        send(1'b1, {2'($urandom), 1'b1, 1'b1}, {2'($urandom), 1'b0, 1'b1},
             {8'($urandom), 8'($urandom), 8'd0, 8'd7});
        check("win3_valid",    80'(out_valid0),      80'(1));
        check("win3_l0_w20",   80'(out_acc0[19:0]),  80'(20'hFFF0D));
        check("win3_l0_w10",   80'(out_acc1[9:0]),   80'(10'h30D));
        check("win3_l1_negz",  80'(out_acc0[39:20]), 80'(0));

        // Backpressure: a last beat of +9 waits while out_ready is low.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, '0, '0, {24'd0, 8'd9}, 1'b0, took);
            check("stall_accept", 80'(took),      80'(0));
            check("stall_ready0", 80'(in_ready0), 80'(0));
            check("stall_ready1", 80'(in_ready1), 80'(0));
            check("stall_ready2", 80'(in_ready2), 80'(0));
        end
        drive(1'b1, 1'b1, '0, '0, {24'd0, 8'd9}, 1'b1, took);
        check("handoff_accept", 80'(took),           80'(1));
        check("handoff_valid",  80'(out_valid0),     80'(1));
        check("handoff_l0",     80'(out_acc0[19:0]), 80'(9));

        // Four beats of +255 on lane 0.
        for (int k = 0; k < 4; k++) send(k == 3, '0, '0, {24'd0, 8'd255});
        check("ovf_w20_acc",  80'(out_acc0[19:0]), 80'(1020));
        check("ovf_w20_flag", 80'(out_ovf0[0]),    80'(0));
        check("ovf_wrap_acc", 80'(out_acc1[9:0]),  80'(10'h3FC));
        check("ovf_wrap_flag",80'(out_ovf1[0]),    80'(1));
        check("ovf_sat_acc",  80'(out_acc2[9:0]),  80'(10'h1FF));
        check("ovf_sat_flag", 80'(out_ovf2[0]),    80'(1));

        // Reset in the middle of a window discards it.
        send(1'b0, '0, '0, {24'd0, 8'd100});
        send(1'b0, '0, '0, {24'd0, 8'd100});
        rst_n = 1'b0;
        drive(1'b1, 1'b0, '0, '0, {24'd0, 8'd100}, 1'b1, took);
        for (int unsigned l = 0; l < LANES; l++) win[l].delete();
        q.delete();
        rst_n = 1'b1;
        check("midrst_accept", 80'(took),       80'(0));
        check("midrst_valid",  80'(out_valid0), 80'(0));
        send(1'b1, '0, '0, {24'd0, 8'd3});
        check("midrst_acc0", 80'(out_acc0[19:0]), 80'(3));
        check("midrst_acc1", 80'(out_acc1[9:0]),  80'(3));
        check("midrst_acc2", 80'(out_acc2[9:0]),  80'(3));
        check("midrst_ovf0", 80'(out_ovf0),       80'(0));
        check("midrst_ovf2", 80'(out_ovf2),       80'(0));

        // Random traffic with random backpressure and extreme magnitudes.
        for (int n = 0; n < 400; n++) begin
            v    = ($urandom % 4) != 0;
            last = ($urandom % 4) == 0;
            ordy = ($urandom % 4) != 0;
            for (int l = 0; l < LANES; l++) begin
                sel = $urandom % 4;
                mv[l*BW +: BW] = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
            end
            drive(v, last, 4'($urandom), 4'($urandom), mv, ordy, took);
        end

        repeat (5) drive(1'b0, 1'b0, '0, '0, '0, 1'b1, took);
        check("drain_queue", 80'(q.size()),   80'(0));
        check("drain_valid", 80'(out_valid0), 80'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
